// File: rtl/ram_sched_pkg.sv
// ram_sched_pkg
// Shared definitions for the SDRAM page scheduler:
//   - default row-address and channel-region widths
//   - FSM state encoding (IDLE / ISSUE / BUSY)
//   - operation encoding used for active_wr (OP_WR = 1, OP_RD = 0)
package ram_sched_pkg;

  localparam int ROW_BITS_DEF = 15;
  localparam int CH_LOG2_DEF  = 14;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2
  } state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Two-way round-robin arbiter with a last-grant register. The channel that
// won most recently gets the lower priority on the next arbitration.
// After reset, channel 1 counts as the last winner, so channel 0 wins first.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   req[1:0]   : request per channel
//   advance    : the current grant is being taken; update the last-grant register
//   grant[1:0] : one-hot grant (combinational), 2'b00 when no request
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic last_q;
  logic last_d;

  // NOTE: every signal written in an always_comb is given a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant = 2'b00;
    if (last_q) begin
      if (req[0])      grant = 2'b01;
      else if (req[1]) grant = 2'b10;
    end else begin
      if (req[1])      grant = 2'b10;
      else if (req[0]) grant = 2'b01;
    end
  end

  always_comb begin
    last_d = last_q;
    if (advance && (grant != 2'b00)) last_d = grant[1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop updates
  // from the values that existed before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/ram_page_scheduler.sv
// ram_page_scheduler
// Schedules page writes (input FIFO -> SDRAM) and page reads (SDRAM -> output
// FIFO) for two channels sharing one sdramctrl. Each channel owns a ring of
// 2^CH_LOG2 rows; rowaddr = {ch, ptr}. Writes always beat reads; each op type
// has its own round-robin between channels.
// Ports:
//   clk, reset                : clock and synchronous active-high reset
//   ch_enable, flush          : per-channel enable and level flush
//   in_ready, out_room        : per-channel FIFO page availability / space
//   cmd_ack, cmd_done         : sdramctrl handshake pulses
//   cmd_pagewrite/pageread    : registered command strobes
//   rowaddr                   : registered row of the current command
//   active_ch, active_wr      : owner and direction of the in-flight command
//   busy                      : FSM in ISSUE or BUSY
//   fill0, fill1, full, empty : committed page counts and their flags
module ram_page_scheduler
  import ram_sched_pkg::*;
#(
  parameter int ROW_BITS = ROW_BITS_DEF,
  parameter int CH_LOG2  = CH_LOG2_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          ch_enable,
  input  logic [1:0]          flush,
  input  logic [1:0]          in_ready,
  input  logic [1:0]          out_room,
  input  logic                cmd_ack,
  input  logic                cmd_done,
  output logic                cmd_pagewrite,
  output logic                cmd_pageread,
  output logic [ROW_BITS-1:0] rowaddr,
  output logic                active_ch,
  output logic                active_wr,
  output logic                busy,
  output logic [CH_LOG2:0]    fill0,
  output logic [CH_LOG2:0]    fill1,
  output logic [1:0]          full,
  output logic [1:0]          empty
);

  localparam logic [CH_LOG2:0]   FILL_MAX = {1'b1, {CH_LOG2{1'b0}}};
  localparam logic [CH_LOG2:0]   FILL_ONE = {{CH_LOG2{1'b0}}, 1'b1};
  localparam logic [CH_LOG2-1:0] PTR_ONE  = {{(CH_LOG2-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic                  cmd_wr_q, cmd_wr_d;
  logic                  cmd_rd_q, cmd_rd_d;
  logic [ROW_BITS-1:0]   rowaddr_q, rowaddr_d;
  logic                  active_ch_q, active_ch_d;
  op_e                   active_wr_q, active_wr_d;
  logic [1:0]            flush_pend_q, flush_pend_d;
  logic [CH_LOG2-1:0]    wr_ptr_q [2];
  logic [CH_LOG2-1:0]    wr_ptr_d [2];
  logic [CH_LOG2-1:0]    rd_ptr_q [2];
  logic [CH_LOG2-1:0]    rd_ptr_d [2];
  logic [CH_LOG2:0]      fill_q   [2];
  logic [CH_LOG2:0]      fill_d   [2];

  logic [1:0] wr_req, rd_req;
  logic [1:0] wr_grant, rd_grant;
  logic       is_idle;
  logic       owned;

  function automatic logic [ROW_BITS-1:0] make_row(input logic ch,
                                                   input logic [CH_LOG2-1:0] ptr);
    return ROW_BITS'({ch, ptr});
  endfunction

  // Flags come from the fill count only: equal pointers mean either full or empty.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      full[c]  = (fill_q[c] == FILL_MAX);
      empty[c] = (fill_q[c] == '0);
    end
  end

  assign wr_req  = ch_enable & in_ready & ~full & ~flush;
  assign rd_req  = ch_enable & out_room & ~empty & ~flush;
  assign is_idle = (state_q == ST_IDLE);

  rr_arbiter2 u_wr_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (wr_req),
    .advance (is_idle && (wr_req != 2'b00)),
    .grant   (wr_grant)
  );

  rr_arbiter2 u_rd_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (rd_req),
    .advance (is_idle && (wr_req == 2'b00) && (rd_req != 2'b00)),
    .grant   (rd_grant)
  );

  always_comb begin
    state_d      = state_q;
    cmd_wr_d     = cmd_wr_q;
    cmd_rd_d     = cmd_rd_q;
    rowaddr_d    = rowaddr_q;
    active_ch_d  = active_ch_q;
    active_wr_d  = active_wr_q;
    flush_pend_d = flush_pend_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fill_d       = fill_q;
    owned        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wr_req != 2'b00) begin
          active_ch_d = wr_grant[1];
          active_wr_d = OP_WR;
          cmd_wr_d    = 1'b1;
          rowaddr_d   = make_row(wr_grant[1], wr_ptr_q[wr_grant[1]]);
          state_d     = ST_ISSUE;
        end else if (rd_req != 2'b00) begin
          active_ch_d = rd_grant[1];
          active_wr_d = OP_RD;
          cmd_rd_d    = 1'b1;
          rowaddr_d   = make_row(rd_grant[1], rd_ptr_q[rd_grant[1]]);
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Command and row are held until the ack is seen; the pointer moves
        // exactly once, on that ack.
        if (cmd_ack) begin
          cmd_wr_d = 1'b0;
          cmd_rd_d = 1'b0;
          if (active_wr_q == OP_WR)
            wr_ptr_d[active_ch_q] = wr_ptr_q[active_ch_q] + PTR_ONE;
          else
            rd_ptr_d[active_ch_q] = rd_ptr_q[active_ch_q] + PTR_ONE;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cmd_done) begin
          if (active_wr_q == OP_WR)
            fill_d[active_ch_q] = fill_q[active_ch_q] + FILL_ONE;
          else
            fill_d[active_ch_q] = fill_q[active_ch_q] - FILL_ONE;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush of a channel with a command in flight is remembered and applied
    // when that command completes, replacing its fill update.
    for (int c = 0; c < 2; c++) begin
      owned = !is_idle && (active_ch_q == c[0]);
      if (flush[c] && !owned) begin
        wr_ptr_d[c]     = '0;
        rd_ptr_d[c]     = '0;
        fill_d[c]       = '0;
        flush_pend_d[c] = 1'b0;
      end else if (owned && (state_q == ST_BUSY) && cmd_done &&
                   (flush_pend_q[c] || flush[c])) begin
        wr_ptr_d[c]     = '0;
        rd_ptr_d[c]     = '0;
        fill_d[c]       = '0;
        flush_pend_d[c] = 1'b0;
      end else if (flush[c] && owned) begin
        flush_pend_d[c] = 1'b1;
      end
    end
  end

  // NOTE: the pointer and fill arrays are ordinary flops, not a RAM, so they
  // take the synchronous reset like every other register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cmd_wr_q     <= 1'b0;
      cmd_rd_q     <= 1'b0;
      rowaddr_q    <= '0;
      active_ch_q  <= 1'b0;
      active_wr_q  <= OP_RD;
      flush_pend_q <= 2'b00;
      for (int c = 0; c < 2; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        fill_q[c]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      cmd_wr_q     <= cmd_wr_d;
      cmd_rd_q     <= cmd_rd_d;
      rowaddr_q    <= rowaddr_d;
      active_ch_q  <= active_ch_d;
      active_wr_q  <= active_wr_d;
      flush_pend_q <= flush_pend_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_q       <= fill_d;
    end
  end

  assign cmd_pagewrite = cmd_wr_q;
  assign cmd_pageread  = cmd_rd_q;
  assign rowaddr       = rowaddr_q;
  assign active_ch     = active_ch_q;
  assign active_wr     = active_wr_q;
  assign busy          = !is_idle;
  assign fill0         = fill_q[0];
  assign fill1         = fill_q[1];

endmodule

// File: doc/ram_page_scheduler.md
RAM_PAGE_SCHEDULER -- requirements
Module: ram_page_scheduler

Interface
REQ-001 Parameter: ROW_BITS, 15, width of the SDRAM row address sent to sdramctrl.
REQ-002 Parameter: CH_LOG2, 14, log2 of rows per channel region; rowaddr = {ch, wr/rd pointer[CH_LOG2-1:0]}.
REQ-003 clk  in  1  single clock, the same clock that drives sdramctrl.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 ch_enable  in  2  per-channel enable; a disabled channel is never granted.
REQ-006 flush  in  2  level, per channel; clears that channel's pointers and fill count.
REQ-007 in_ready  in  2  per channel, input FIFO holds at least one page (~prog_empty).
REQ-008 out_room  in  2  per channel, output FIFO can accept one page (~prog_full).
REQ-009 cmd_ack  in  1  sdramctrl accepted the command (one-cycle pulse).
REQ-010 cmd_done  in  1  sdramctrl finished the page transfer (one-cycle pulse).
REQ-011 cmd_pagewrite  out  1  page-write request to sdramctrl, registered.
REQ-012 cmd_pageread  out  1  page-read request to sdramctrl, registered.
REQ-013 rowaddr  out  ROW_BITS  row for the current command, registered.
REQ-014 active_ch  out  1  channel owning the in-flight command; drives the FIFO muxes.
REQ-015 active_wr  out  1  1 = in-flight op is a write, 0 = read.
REQ-016 busy  out  1  high in ISSUE and BUSY.
REQ-017 fill0, fill1  out  CH_LOG2+1  committed page count per channel.
REQ-018 full, empty  out  2  per channel: fill == 2^CH_LOG2, fill == 0.

Function
REQ-019 FSM states: IDLE, ISSUE, BUSY.
REQ-020 Eligibility: wr_req[c] = ch_enable[c] & in_ready[c] & ~full[c] & ~flush[c]; rd_req[c] = ch_enable[c] & out_room[c] & ~empty[c] & ~flush[c].
REQ-021 IDLE: any wr_req wins over every rd_req. Within writes, a 2-way round-robin picks the channel; within reads, an independent round-robin does. The grant, channel and op latch in that cycle and the FSM moves to ISSUE. With no request the FSM stays in IDLE.
REQ-022 Round-robin: the last granted channel of that op type has lowest priority next time; both pointers reset to channel 1 as last, so channel 0 wins first.
REQ-023 ISSUE: cmd_pagewrite or cmd_pageread and rowaddr are asserted from the first ISSUE cycle, which is one cycle after the IDLE decision. They stay asserted until cmd_ack is sampled high and deassert on the following cycle.
REQ-024 On cmd_ack, the granted channel's wr_ptr or rd_ptr increments modulo 2^CH_LOG2 and the FSM moves to BUSY; a cmd_ack in IDLE or BUSY is ignored.
REQ-025 BUSY: on cmd_done, fill[c] +1 for a write or -1 for a read, and the FSM returns to IDLE; the next grant is evaluated in that IDLE cycle, giving a minimum 1-cycle gap.
REQ-026 full/empty derive combinationally from fill; wr_ptr == rd_ptr is ambiguous and is never used for them.
REQ-027 Pointer wrap: row 2^CH_LOG2-1 is followed by row 0 of the same channel region; the ch bit is never carried into.
REQ-028 Flush on a non-active channel, or any channel in IDLE: wr_ptr, rd_ptr and fill clear to 0 the next cycle.
REQ-029 Flush on the active channel while busy: deferred; applied in the cycle after cmd_done, overriding that done's fill update.
REQ-030 active_ch and active_wr hold their last value while in IDLE.

Reset
REQ-031 Reset synchronous, active-high, with priority over all inputs, including mid-command.
REQ-032 Reset values: FSM = IDLE, cmd_pagewrite = cmd_pageread = 0, rowaddr = 0, active_ch = 0, active_wr = 0, busy = 0, all pointers and fill = 0, empty = 2'b11, full = 2'b00, RR pointers as REQ-022.
REQ-033 An acknowledged command cut off by reset is discarded; sdramctrl is reset by the same signal.

Structure
REQ-034 Package ram_sched_pkg holds ROW_BITS, CH_LOG2 defaults, the FSM state encoding and the op encoding (OP_WR = 1, OP_RD = 0).
REQ-035 One sub-module, rr_arbiter2 (2 requests, last-grant register, grant one-hot), is instantiated twice: once for writes and once for reads.
REQ-036 Target 150-300 lines of RTL in total.

Verification
REQ-037 After reset, in_ready = 01, ch_enable = 11 -> cmd_pagewrite high 2 cycles later with rowaddr = 0x0000; after ack and done, fill0 = 1.
REQ-038 in_ready = 11 and out_room = 11 held, every command acked and done -> grants W0, W1, W0, W1 and no reads until in_ready = 00, then R0, R1 alternate.
REQ-039 Channel 1: 16384 writes -> full[1] = 1 and wr_req blocked. One read -> rowaddr = 0x4000, full[1] = 0. The next write uses rowaddr 0x4000, showing the wrap.
REQ-040 Hold cmd_ack low for 10 cycles in ISSUE -> cmd and rowaddr stable for all 10 cycles, pointer unchanged, fill unchanged.
REQ-041 flush[0] asserted in BUSY on a ch0 write with fill0 = 5 -> fill0 = 6 is never observed; fill0 = 0 the cycle after cmd_done.
REQ-042 Assert reset in BUSY with fill0 = 3 -> next cycle: IDLE, cmds 0, fill0 = 0, empty = 11; a subsequent late cmd_done is ignored.
